// File: rtl/dot_product_ctrl_if.sv
// Handshake and memory bus bundle for the dot-product controller.
// Carries start/length, shared A/B read port, gated host write and result.
//
// Ports (signals):
//   start, length             request a dot product of length elements
//   busy                      controller not idle
//   rd_en, rd_addr            shared read strobe/address for memories A and B
//   a_data, b_data            read data, one cycle after rd_en
//   host_wr_en                host write request
//   mem_wr_en, host_wr_stall  gated write enable / write blocked
//   result, result_valid      unsigned dot product and its valid flag
//   result_ready              consumer accepts result
// Modports: slave = controller side, master = host/memory side.
interface dot_product_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
);
    logic                  start;
    logic [ADDR_WIDTH:0]   length;
    logic                  busy;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] a_data;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  host_wr_en;
    logic                  mem_wr_en;
    logic                  host_wr_stall;
    logic [ACC_WIDTH-1:0]  result;
    logic                  result_valid;
    logic                  result_ready;

    modport slave (
        input  start, length, a_data, b_data,
        input  host_wr_en, result_ready,
        output busy, rd_en, rd_addr,
        output mem_wr_en, host_wr_stall,
        output result, result_valid
    );

    modport master (
        output start, length, a_data, b_data,
        output host_wr_en, result_ready,
        input  busy, rd_en, rd_addr,
        input  mem_wr_en, host_wr_stall,
        input  result, result_valid
    );
endinterface

// File: rtl/dot_product_ctrl.sv
// Dot-product controller: streams N element pairs from memories A and B,
// accumulates a_data*b_data, and hands the sum out with a valid/ready pair.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  dot_product_ctrl_if.slave (start/length, read port, host write
//        gating, result handshake)
module dot_product_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    dot_product_ctrl_if.slave    bus
);

    localparam int PROD_WIDTH = 2*DATA_WIDTH;

    localparam logic [ADDR_WIDTH:0] MAX_LEN =
        {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LEN_ONE =
        {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE =
        {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   count;
    logic [ACC_WIDTH-1:0]  acc;
    logic                  rd_en_q;
    logic                  rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  busy_q;
    logic [ACC_WIDTH-1:0]  result_q;
    logic                  result_valid_q;

    logic [ADDR_WIDTH:0]   sat_len;
    logic                  last_addr;
    logic [PROD_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]  acc_next;

    // Oversized requests are clamped to the memory depth.
    assign sat_len = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;

    assign last_addr = ({1'b0, rd_addr_q} == (count - LEN_ONE));

    assign prod = {{DATA_WIDTH{1'b0}}, bus.a_data}
                * {{DATA_WIDTH{1'b0}}, bus.b_data};

    // rd_en_d marks the cycle in which the read data for the previous
    // address is present on a_data/b_data.
    assign acc_next = rd_en_d
        ? acc + {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, prod}
        : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            count          <= '0;
            acc            <= '0;
            rd_en_q        <= 1'b0;
            rd_en_d        <= 1'b0;
            rd_addr_q      <= '0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            rd_en_d <= rd_en_q;
            acc     <= acc_next;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        busy_q <= 1'b1;
                        if (sat_len == '0) begin
                            count          <= '0;
                            result_q       <= '0;
                            result_valid_q <= 1'b1;
                            state          <= DONE;
                        end else begin
                            count     <= sat_len;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= '0;
                            state     <= READ;
                        end
                    end
                end
                READ: begin
                    if (last_addr) begin
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                        state     <= DRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    // Final element arrives this cycle; fold it in directly.
                    result_q       <= acc_next;
                    result_valid_q <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    if (bus.result_ready) begin
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.rd_en        = rd_en_q;
    assign bus.rd_addr      = rd_addr_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;

    // Host writes pass only while idle so they never race a read burst.
    assign bus.mem_wr_en     = bus.host_wr_en & (state == IDLE) & ~rst;
    assign bus.host_wr_stall = bus.host_wr_en & (state != IDLE) & ~rst;

endmodule
